// File: rtl/shoelace_pkg.sv
// -----------------------------------------------------------------------------
// shoelace_pkg
// Shared definitions for the shoelace ring sequencer:
//   state_e          - sequencer states (also exposed on the debug port)
//   DEFAULT_TIMEOUT  - default settle timeout in clock cycles
//   lat_ones()       - all-ones value of a given width, used as the
//                      "no latency seen yet" value of the running minimum
// -----------------------------------------------------------------------------
package shoelace_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_DRIVE = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam int DEFAULT_TIMEOUT = 1000;

  // All-ones of width w (w up to 64); callers truncate to their width.
  function automatic logic [63:0] lat_ones(input int unsigned w);
    if (w >= 64) begin
      return '1;
    end
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// -----------------------------------------------------------------------------
// sync_bit
// Multi-flop synchronizer for a single bit arriving from an asynchronous
// domain (prsim chain outputs). Flops reset to 0.
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset
//   i_d    - asynchronous input bit
//   o_q    - synchronized output (last flop of the chain)
// -----------------------------------------------------------------------------
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/shoelace_ring_ctrl.sv
// -----------------------------------------------------------------------------
// shoelace_ring_ctrl
// Drives a programmed number of transitions into an inverter chain, waits for
// the chain output to settle to the expected polarity after each one, and
// records per-transition latency (in clk cycles, synchronizer included).
//
// Handshake: start is a level sampled only in IDLE; a run is in progress while
// busy=1; done is a single-cycle pulse on normal completion (including a
// timeout). abort returns to IDLE on the next cycle from any non-IDLE state
// without a done pulse and without touching ring_in or the statistics.
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   start, abort   - run control
//   num_toggles    - transitions for the run (captured at start)
//   ring_in        - registered drive into the chain input
//   ring_out       - chain output (asynchronous to clk)
//   busy, done     - run status
//   timeout_flag   - sticky until the next start; run ended on timeout
//   lat_last/min/max, toggles_done - run statistics
//   dbg_state      - current sequencer state (shoelace_pkg::state_e encoding)
// -----------------------------------------------------------------------------
module shoelace_ring_ctrl
  import shoelace_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int NUM_W       = 8,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int INVERT      = 1,
  parameter int SYNC_STAGES = 2,
  parameter int GAP         = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [NUM_W-1:0] num_toggles,
  output logic             ring_in,
  input  logic             ring_out,
  output logic             busy,
  output logic             done,
  output logic             timeout_flag,
  output logic [CNT_W-1:0] lat_last,
  output logic [CNT_W-1:0] lat_min,
  output logic [CNT_W-1:0] lat_max,
  output logic [NUM_W-1:0] toggles_done,
  output logic [2:0]       dbg_state
);

  localparam logic [CNT_W-1:0] LAT_ONES   = CNT_W'(lat_ones(CNT_W));
  localparam logic [CNT_W-1:0] TMO        = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic             INV_BIT    = 1'(INVERT);

  state_e           r_state, w_state_nxt;
  logic             r_ring_in, w_ring_in_nxt;
  logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic [CNT_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
  logic [NUM_W-1:0] r_num, w_num_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [CNT_W-1:0] r_lat_last, w_lat_last_nxt;
  logic [CNT_W-1:0] r_lat_min, w_lat_min_nxt;
  logic [CNT_W-1:0] r_lat_max, w_lat_max_nxt;
  logic [NUM_W-1:0] r_toggles, w_toggles_nxt;

  logic             w_s_out;
  logic             w_settled;
  logic [NUM_W-1:0] w_toggles_inc;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync_out (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (ring_out),
    .o_q   (w_s_out)
  );

  // Expected polarity follows the current drive; after DRIVE this is already
  // the new value, so WAIT compares against the post-transition target.
  assign w_settled     = (w_s_out == (r_ring_in ^ INV_BIT));
  assign w_toggles_inc = r_toggles + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ring_in  <= 1'b0;
      r_wait_cnt <= '0;
      r_gap_cnt  <= '0;
      r_num      <= '0;
      r_timeout  <= 1'b0;
      r_lat_last <= '0;
      r_lat_min  <= LAT_ONES;
      r_lat_max  <= '0;
      r_toggles  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ring_in  <= w_ring_in_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_num      <= w_num_nxt;
      r_timeout  <= w_timeout_nxt;
      r_lat_last <= w_lat_last_nxt;
      r_lat_min  <= w_lat_min_nxt;
      r_lat_max  <= w_lat_max_nxt;
      r_toggles  <= w_toggles_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ring_in_nxt  = r_ring_in;
    w_wait_cnt_nxt = r_wait_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_num_nxt      = r_num;
    w_timeout_nxt  = r_timeout;
    w_lat_last_nxt = r_lat_last;
    w_lat_min_nxt  = r_lat_min;
    w_lat_max_nxt  = r_lat_max;
    w_toggles_nxt  = r_toggles;

    // abort wins over every settle/timeout decision and freezes all data.
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_timeout_nxt  = 1'b0;
            w_toggles_nxt  = '0;
            w_lat_min_nxt  = LAT_ONES;
            w_lat_max_nxt  = '0;
            w_wait_cnt_nxt = '0;
            w_num_nxt      = num_toggles;
            w_state_nxt    = S_ARM;
          end
        end

        S_ARM: begin
          if (w_settled) begin
            w_state_nxt = (r_num == '0) ? S_DONE : S_DRIVE;
          end else if (r_wait_cnt == TMO) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = S_DONE;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
          end
        end

        S_DRIVE: begin
          w_ring_in_nxt  = ~r_ring_in;
          w_wait_cnt_nxt = CNT_W'(1);
          w_state_nxt    = S_WAIT;
        end

        S_WAIT: begin
          if (w_settled) begin
            w_lat_last_nxt = r_wait_cnt;
            if (r_wait_cnt < r_lat_min) begin
              w_lat_min_nxt = r_wait_cnt;
            end
            if (r_wait_cnt > r_lat_max) begin
              w_lat_max_nxt = r_wait_cnt;
            end
            w_toggles_nxt = w_toggles_inc;
            if (w_toggles_inc == r_num) begin
              w_state_nxt = S_DONE;
            end else if (GAP > 0) begin
              w_gap_cnt_nxt = '0;
              w_state_nxt   = S_GAP;
            end else begin
              w_state_nxt = S_DRIVE;
            end
          end else if (r_wait_cnt == TMO) begin
            w_timeout_nxt  = 1'b1;
            w_lat_last_nxt = TMO;
            w_state_nxt    = S_DONE;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            w_state_nxt = S_DRIVE;
          end else begin
            w_gap_cnt_nxt = r_gap_cnt + 1'b1;
          end
        end

        S_DONE: begin
          w_state_nxt = S_IDLE;
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign ring_in      = r_ring_in;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign timeout_flag = r_timeout;
  assign lat_last     = r_lat_last;
  assign lat_min      = r_lat_min;
  assign lat_max      = r_lat_max;
  assign toggles_done = r_toggles;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_shoelace_ring_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shoelace_ring_ctrl
// Bench for shoelace_ring_ctrl with a clocked inverter-chain model whose
// delay can be set per transition and which can be made to stick.
// -----------------------------------------------------------------------------
module tb_shoelace_ring_ctrl;
  import shoelace_pkg::*;

  localparam int CNT_W = 16;
  localparam int NUM_W = 8;
  localparam int W     = 66;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [NUM_W-1:0] num_toggles = '0;
  logic             ring_in;
  logic             ring_out;
  logic             busy, done, timeout_flag;
  logic [CNT_W-1:0] lat_last, lat_min, lat_max;
  logic [NUM_W-1:0] toggles_done;
  logic [2:0]       dbg_state;

  shoelace_ring_ctrl #(
    .CNT_W(CNT_W), .NUM_W(NUM_W), .TIMEOUT(20),
    .INVERT(1), .SYNC_STAGES(2), .GAP(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_toggles(num_toggles), .ring_in(ring_in), .ring_out(ring_out),
    .busy(busy), .done(done), .timeout_flag(timeout_flag),
    .lat_last(lat_last), .lat_min(lat_min), .lat_max(lat_max),
    .toggles_done(toggles_done), .dbg_state(dbg_state)
  );

  // chain model: odd stage count, output = ~ring_in delayed by cur_dly edges
  logic [7:0] hist     = '0;
  logic [7:0] tog_cnt  = '0;
  logic [7:0] tog_base = '0;
  logic [7:0] stuck_at = 8'hff;
  logic [7:0] run_idx;
  int         dly_tbl [16];
  int         cur_dly;
  logic       tap;

  always @(posedge clk) hist <= {hist[6:0], ring_in};
  always @(ring_in) tog_cnt <= tog_cnt + 8'd1;

  always_comb begin
    run_idx = tog_cnt - tog_base;
    cur_dly = dly_tbl[run_idx[3:0]];
    tap     = (cur_dly == 0) ? ring_in : hist[cur_dly-1];
    // a stuck chain keeps showing the pre-transition (unsettled) level
    ring_out = (run_idx >= stuck_at) ? ring_in : ~tap;
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic push_exp(input logic [15:0] last, input logic [15:0] mn, input logic [15:0] mx,
                          input logic [7:0] tog, input logic to, input logic rin,
                          input logic [7:0] seen);
    exp_q.push_back({seen, rin, to, tog, mx, mn, last});
  endtask

  // monitor: compare the run statistics whenever done is presented
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: done=1 expected 0 (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("lat_last",     lat_last,         e[15:0]);
        check("lat_min",      lat_min,          e[31:16]);
        check("lat_max",      lat_max,          e[47:32]);
        check("toggles_done", toggles_done,     e[55:48]);
        check("timeout_flag", timeout_flag,     e[56]);
        check("ring_in_end",  ring_in,          e[57]);
        check("ring_toggles", tog_cnt-tog_base, e[65:58]);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_dly(input int d);
    for (int i = 0; i < 16; i++) dly_tbl[i] = d;
  endtask

  task automatic pulse_start(input logic [7:0] n);
    @(negedge clk);
    num_toggles = n;
    tog_base    = tog_cnt;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin @(negedge clk); n++; end
    check("idle_reached", busy, 0);
  endtask

  task automatic wait_in_wait(input logic [7:0] tog);
    int n = 0;
    while (!(toggles_done == tog && dbg_state == S_WAIT) && n < 1000) begin
      @(negedge clk); n++;
    end
    check("reach_wait", {toggles_done, dbg_state}, {tog, 3'(S_WAIT)});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ring_in"},  ring_in,      0);
    check({tag, "_busy"},     busy,         0);
    check({tag, "_done"},     done,         0);
    check({tag, "_timeout"},  timeout_flag, 0);
    check({tag, "_lat_last"}, lat_last,     0);
    check({tag, "_lat_min"},  lat_min,      16'hffff);
    check({tag, "_lat_max"},  lat_max,      0);
    check({tag, "_toggles"},  toggles_done, 0);
    check({tag, "_state"},    dbg_state,    3'(S_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_dly(3);
    tick(3);
    check_reset_values("rst");
    rst_n = 1'b1;
    tick(6);
    check_reset_values("post_rst");

    // T1: constant 3-cycle chain, 4 transitions: latency 3+2+1 = 6
    push_exp(16'd6, 16'd6, 16'd6, 8'd4, 1'b0, 1'b0, 8'd4);
    pulse_start(8'd4);
    wait_idle();
    tick(4);

    // T2: delays 1,5,2 -> latencies 4,8,5
    dly_tbl[1] = 1; dly_tbl[2] = 5; dly_tbl[3] = 2;
    push_exp(16'd5, 16'd4, 16'd8, 8'd3, 1'b0, 1'b1, 8'd3);
    pulse_start(8'd3);
    wait_idle();
    tick(8);

    // T4: zero transitions on a settled ring; done two cycles after start
    set_dly(1);
    push_exp(16'd5, 16'hffff, 16'd0, 8'd0, 1'b0, 1'b1, 8'd0);
    pulse_start(8'd0);
    check("zero_state_arm", dbg_state, 3'(S_ARM));
    check("zero_done_c1",   done,      0);
    @(negedge clk);
    check("zero_done_c2",   done,      1);
    @(negedge clk);
    check("zero_done_c3",   done,      0);
    check("zero_busy_c3",   busy,      0);
    check("zero_ring_in",   ring_in,   1);
    tick(4);

    // T3: chain sticks on the 3rd transition, TIMEOUT=20
    stuck_at = 8'd3;
    push_exp(16'd20, 16'd4, 16'd4, 8'd2, 1'b1, 1'b0, 8'd3);
    pulse_start(8'd5);
    wait_idle();
    tick(3);
    check("timeout_sticky", timeout_flag, 1);
    stuck_at = 8'hff;
    tick(8);

    // T5: abort in the 2nd WAIT of a 6-transition run (latency 5)
    set_dly(2);
    pulse_start(8'd6);
    check("start_clears_timeout", timeout_flag, 0);
    wait_in_wait(8'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_state",    dbg_state,    3'(S_IDLE));
    check("abort_busy",     busy,         0);
    check("abort_done",     done,         0);
    check("abort_toggles",  toggles_done, 1);
    check("abort_ring_in",  ring_in,      0);
    check("abort_lat_last", lat_last,     5);
    tick(10);
    check("abort_hold_ring_in", ring_in, 0);
    push_exp(16'd5, 16'd5, 16'd5, 8'd1, 1'b0, 1'b1, 8'd1);
    pulse_start(8'd1);
    wait_idle();
    tick(8);

    // T6: start while busy is ignored, count stays as captured
    set_dly(1);
    push_exp(16'd4, 16'd4, 16'd4, 8'd3, 1'b0, 1'b0, 8'd3);
    pulse_start(8'd3);
    wait_in_wait(8'd1);
    num_toggles = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ignored", dbg_state != 3'(S_ARM), 1);
    wait_idle();
    tick(8);

    // T7: asynchronous reset between edges in the middle of a WAIT
    set_dly(5);
    pulse_start(8'd4);
    wait_in_wait(8'd1);
    tick(2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick(10);
    check("idle_after_rst", dbg_state, 3'(S_IDLE));
    check("pending_done", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
